stepper_axes_ctrl: RTL and testbench

Parametrised multi-channel step/dir pulse generator. It is the next generation of the two-motor CoreXY driver block.
- Drives NUM_CH motors from signed per-channel step counts and per-channel half-period speeds.
- Endstop blocking is evaluated in machine-axis space, with selectable Cartesian or CoreXY kinematics.
- Adds a start/busy/done handshake, abort, a fault flag and a live remaining-steps readback.
- Sits between the UART command decoder and the motor driver pins.

---
 rtl/stepper_pkg.sv | 30 +++
 rtl/stepper_chan.sv | 95 +++++++++
 rtl/stepper_axes_ctrl.sv | 159 +++++++++++++++
 tb/tb_stepper_axes_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the multi-channel step/dir generator.
package stepper_pkg;

    // Controller states, kept as plain constants for legacy tooling.
    typedef logic [1:0] state_t;
    localparam state_t StIdle   = 2'd0;
    localparam state_t StRun    = 2'd1;
    localparam state_t StFinish = 2'd2;

    // Machine-axis motion sign.
    typedef enum logic [1:0] {
        SignZero = 2'd0,
        SignNeg  = 2'd1,
        SignPos  = 2'd2
    } axis_sign_e;

    // Channels forming the CoreXY pair.
    localparam int unsigned XyChA = 0;
    localparam int unsigned XyChB = 1;

    function automatic axis_sign_e sign_of(input logic is_zero, input logic is_neg);
        if (is_zero) begin
            return SignZero;
        end else if (is_neg) begin
            return SignNeg;
        end
        return SignPos;
    endfunction

endpackage

// File: rtl/stepper_chan.sv
// One step/dir channel: half-period phase counter, step magnitude and
// signed remaining-steps counter.
module stepper_chan
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_W = 32,
    parameter int unsigned PER_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              run,
    input  logic              kill,
    input  logic [STEP_W-1:0] steps,
    input  logic [PER_W-1:0]  half_period,
    output logic              step,
    output logic              dir,
    output logic              active,
    output logic [STEP_W-1:0] remaining
);

    localparam logic [PER_W-1:0]  PerOne  = PER_W'(1);
    localparam logic [STEP_W:0]   MagOne  = (STEP_W + 1)'(1);
    localparam logic [STEP_W-1:0] StepOne = STEP_W'(1);

    logic [PER_W-1:0]  hp_q, hp_d, cnt_q, cnt_d;
    logic [STEP_W:0]   mag_q, mag_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              step_q, step_d, dir_q, dir_d;
    logic [STEP_W:0]   steps_ext;
    logic [PER_W-1:0]  hp_eff;
    logic              issue;

    // One extra bit so the most negative count has an exact magnitude.
    assign steps_ext = {steps[STEP_W-1], steps};
    assign hp_eff    = (half_period == '0) ? PerOne : half_period;

    always_comb begin
        hp_d   = hp_q;
        cnt_d  = cnt_q;
        mag_d  = mag_q;
        rem_d  = rem_q;
        step_d = step_q;
        dir_d  = dir_q;
        issue  = 1'b0;
        if (load) begin
            hp_d   = hp_eff;
            cnt_d  = hp_eff - PerOne;
            mag_d  = steps[STEP_W-1] ? -steps_ext : steps_ext;
            rem_d  = steps;
            dir_d  = steps[STEP_W-1];
            step_d = 1'b0;
        end else if (kill) begin
            // A pulse cut short still counts as issued.
            step_d = 1'b0;
            issue  = step_q;
        end else if (run && (mag_q != '0)) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - PerOne;
            end else begin
                cnt_d  = hp_q - PerOne;
                step_d = ~step_q;
                issue  = step_q;
            end
        end
        if (issue) begin
            mag_d = mag_q - MagOne;
            rem_d = dir_q ? rem_q + StepOne : rem_q - StepOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q   <= '0;
            cnt_q  <= '0;
            mag_q  <= '0;
            rem_q  <= '0;
            step_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            hp_q   <= hp_d;
            cnt_q  <= cnt_d;
            mag_q  <= mag_d;
            rem_q  <= rem_d;
            step_q <= step_d;
            dir_q  <= dir_d;
        end
    end

    assign step      = step_q;
    assign dir       = dir_q;
    assign active    = (mag_q != '0);
    assign remaining = rem_q;

endmodule

// File: rtl/stepper_axes_ctrl.sv
// Multi-channel step/dir generator with start/busy/done handshake, abort and
// kinematics-aware endstop blocking. Define ENDSTOP_FILTER_EN to synchronise and debounce endstops.
module stepper_axes_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned STEP_W = 32,
    parameter int unsigned PER_W  = 32,
    parameter int unsigned COREXY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_CH*STEP_W-1:0] steps_in,
    input  logic [NUM_CH*PER_W-1:0]  half_period_in,
    input  logic [NUM_CH-1:0]        endstop_min,
    input  logic [NUM_CH-1:0]        endstop_max,
    output logic [NUM_CH-1:0]        step_out,
    output logic [NUM_CH-1:0]        dir_out,
    output logic                     busy,
    output logic                     done,
    output logic                     endstop_hit,
    output logic [NUM_CH*STEP_W-1:0] steps_remaining
);

    state_t                  state_q, state_d;
    logic                    hit_q, hit_d;
    logic [NUM_CH-1:0][1:0]  axis_q, axis_d;
    logic [NUM_CH-1:0]       active;
    logic [NUM_CH-1:0]       es_min, es_max;
    logic                    accept, all_zero, block, kill;
    logic [STEP_W-1:0]       s_a, s_b;
    logic [STEP_W:0]         xy_sum, xy_diff;

    assign accept   = (state_q == StIdle) && start;
    assign all_zero = (steps_in == '0);
    assign kill     = (state_q == StRun) && (block || abort);

    // CoreXY pair sums at one extra bit so they never wrap.
    assign s_a     = steps_in[XyChA*STEP_W +: STEP_W];
    assign s_b     = steps_in[XyChB*STEP_W +: STEP_W];
    assign xy_sum  = {s_a[STEP_W-1], s_a} + {s_b[STEP_W-1], s_b};
    assign xy_diff = {s_a[STEP_W-1], s_a} - {s_b[STEP_W-1], s_b};

    always_comb begin
        axis_d = axis_q;
        if (accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                axis_d[i] = sign_of(steps_in[i*STEP_W +: STEP_W] == '0,
                                    steps_in[i*STEP_W + STEP_W - 1]);
            end
            if (COREXY != 0) begin
                axis_d[XyChA] = sign_of(xy_sum == '0, xy_sum[STEP_W]);
                axis_d[XyChB] = sign_of(xy_diff == '0, xy_diff[STEP_W]);
            end
        end
    end

`ifdef ENDSTOP_FILTER_EN
    // Two-flop synchroniser, then a level is accepted after three equal samples.
    logic [2*NUM_CH-1:0] es_raw, sync1_q, sync2_q, hist0_q, hist1_q, filt_q, es_eq;

    assign es_raw = {endstop_max, endstop_min};
    assign es_eq  = ~(sync2_q ^ hist0_q) & ~(hist0_q ^ hist1_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist0_q <= '0;
            hist1_q <= '0;
            filt_q  <= '0;
        end else begin
            sync1_q <= es_raw;
            sync2_q <= sync1_q;
            hist0_q <= sync2_q;
            hist1_q <= hist0_q;
            filt_q  <= (es_eq & hist1_q) | (~es_eq & filt_q);
        end
    end

    assign es_min = filt_q[NUM_CH-1:0];
    assign es_max = filt_q[2*NUM_CH-1:NUM_CH];
`else
    assign es_min = endstop_min;
    assign es_max = endstop_max;
`endif

    always_comb begin
        block = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (((axis_q[i] == SignNeg) && es_min[i]) || ((axis_q[i] == SignPos) && es_max[i])) begin
                block = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = all_zero ? StFinish : StRun;
                    hit_d   = 1'b0;
                end
            end
            StRun: begin
                if (block || abort) begin
                    state_d = StFinish;
                    if (block) begin
                        hit_d = 1'b1;
                    end
                end else if (active == '0) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            hit_q   <= 1'b0;
            axis_q  <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            axis_q  <= axis_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        stepper_chan #(
            .STEP_W(STEP_W),
            .PER_W (PER_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .load       (accept),
            .run        (state_q == StRun),
            .kill       (kill),
            .steps      (steps_in[g*STEP_W +: STEP_W]),
            .half_period(half_period_in[g*PER_W +: PER_W]),
            .step       (step_out[g]),
            .dir        (dir_out[g]),
            .active     (active[g]),
            .remaining  (steps_remaining[g*STEP_W +: STEP_W])
        );
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StFinish);
    assign endstop_hit = hit_q;

endmodule

// File: tb/tb_stepper_axes_ctrl.sv
// Bench for stepper_axes_ctrl: directed scenarios plus randomized moves
// checked cycle by cycle against an arithmetic pulse-timing model.
module tb_stepper_axes_ctrl;

    localparam int NCH = 3;
    localparam int SW  = 32;
    localparam int PW  = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [NCH*SW-1:0]   steps_in = '0;
    logic [NCH*PW-1:0]   half_period_in = '0;
    logic [NCH-1:0]      endstop_min = '0;
    logic [NCH-1:0]      endstop_max = '0;
    logic [NCH-1:0]      step_out, dir_out;
    logic                busy, done, endstop_hit;
    logic [NCH*SW-1:0]   steps_remaining;

    int n_vec  = 0;
    int n_fail = 0;

    longint m_steps[NCH];
    longint m_hp_raw[NCH];
    longint m_hp[NCH];

    stepper_axes_ctrl #(
        .NUM_CH(NCH),
        .STEP_W(SW),
        .PER_W (PW),
        .COREXY(1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .steps_in       (steps_in),
        .half_period_in (half_period_in),
        .endstop_min    (endstop_min),
        .endstop_max    (endstop_max),
        .step_out       (step_out),
        .dir_out        (dir_out),
        .busy           (busy),
        .done           (done),
        .endstop_hit    (endstop_hit),
        .steps_remaining(steps_remaining)
    );

    always #5 clk = ~clk;

    // ---- reference model: k = number of RUN clock edges since the start edge ----
    function automatic longint m_mag(int c);
        return (m_steps[c] < 0) ? -m_steps[c] : m_steps[c];
    endfunction

    function automatic longint m_issued(int c, longint k);
        longint p = k / (2 * m_hp[c]);
        return (p < m_mag(c)) ? p : m_mag(c);
    endfunction

    function automatic longint m_high(int c, longint k);
        return (((k / m_hp[c]) % 2 == 1) && (k / (2 * m_hp[c]) < m_mag(c))) ? 1 : 0;
    endfunction

    function automatic longint m_rem(int c, longint issued);
        return (m_steps[c] < 0) ? m_steps[c] + issued : m_steps[c] - issued;
    endfunction

    function automatic longint m_last_edge();
        longint mx = 0;
        for (int c = 0; c < NCH; c++) begin
            if (2 * m_hp[c] * m_mag(c) > mx) mx = 2 * m_hp[c] * m_mag(c);
        end
        return mx;
    endfunction

    function automatic int m_axis_dir(int a);
        longint v;
        if (a == 0) v = m_steps[0] + m_steps[1];
        else if (a == 1) v = m_steps[0] - m_steps[1];
        else v = m_steps[a];
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    task automatic apply_move();
        for (int c = 0; c < NCH; c++) begin
            steps_in[c*SW +: SW]       = m_steps[c][SW-1:0];
            half_period_in[c*PW +: PW] = m_hp_raw[c][PW-1:0];
            m_hp[c] = (m_hp_raw[c] == 0) ? 1 : m_hp_raw[c];
        end
    endtask

    // Returns at the falling edge following the accepting clock edge (k = 0).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_vec += 6;
        if (step_out !== '0) begin n_fail++; $display("FAIL reset_step got %b want 0", step_out); end
        if (dir_out !== '0) begin n_fail++; $display("FAIL reset_dir got %b want 0", dir_out); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (endstop_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", endstop_hit); end
        if (steps_remaining !== '0) begin
            n_fail++; $display("FAIL reset_rem got %h want 0", steps_remaining);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [NCH-1:0] prev;
        int rises[NCH];
        int last_rise[NCH];
        int n_done = 0;
        int done_k = -1;
        m_steps  = '{5, -3, 0};
        m_hp_raw = '{2, 4, 1};
        apply_move();
        pulse_start();
        n_vec += 2;
        if (dir_out !== 3'b010) begin n_fail++; $display("FAIL basic_dir got %b want 010", dir_out); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
        prev = step_out;
        for (int c = 0; c < NCH; c++) begin rises[c] = 0; last_rise[c] = -1; end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (step_out[c] && !prev[c]) begin rises[c]++; last_rise[c] = k; end
            end
            prev = step_out;
            if (done) begin n_done++; done_k = k; end
        end
        n_vec += 8;
        if (rises[0] != 5) begin n_fail++; $display("FAIL basic_pulses0 got %0d want 5", rises[0]); end
        if (rises[1] != 3) begin n_fail++; $display("FAIL basic_pulses1 got %0d want 3", rises[1]); end
        if (rises[2] != 0) begin n_fail++; $display("FAIL basic_pulses2 got %0d want 0", rises[2]); end
        if (last_rise[0] != 18) begin n_fail++; $display("FAIL basic_period0 got %0d want 18", last_rise[0]); end
        if (last_rise[1] != 20) begin n_fail++; $display("FAIL basic_period1 got %0d want 20", last_rise[1]); end
        if (n_done != 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", n_done); end
        if (done_k != 25) begin n_fail++; $display("FAIL basic_done_time got %0d want 25", done_k); end
        if (steps_remaining !== '0) begin
            n_fail++; $display("FAIL basic_rem got %h want 0", steps_remaining);
        end
    endtask

    task automatic test_zero();
        int n_done = 0;
        int n_busy = 0;
        int n_rise = 0;
        m_steps  = '{0, 0, 0};
        m_hp_raw = '{3, 0, 2};
        apply_move();
        pulse_start();
        n_vec++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
        for (int k = 0; k < 5; k++) begin
            if (done) n_done++;
            if (busy) n_busy++;
            if (step_out != '0) n_rise++;
            @(negedge clk);
        end
        n_vec += 3;
        if (n_done != 1) begin n_fail++; $display("FAIL zero_done_count got %0d want 1", n_done); end
        if (n_busy != 0) begin n_fail++; $display("FAIL zero_busy got %0d want 0", n_busy); end
        if (n_rise != 0) begin n_fail++; $display("FAIL zero_steps got %0d want 0", n_rise); end
    endtask

    task automatic test_endstop();
        int rises0 = 0;
        int rises1 = 0;
        int done_k = -1;
        logic [NCH-1:0] prev;
        // X moving positive hits its max endstop after three full pulses.
        m_steps  = '{10, 10, 0};
        m_hp_raw = '{1, 1, 1};
        apply_move();
        pulse_start();
        repeat (6) @(negedge clk);
        endstop_max = 3'b001;
        @(negedge clk);
        n_vec += 4;
        if (done !== 1'b1) begin n_fail++; $display("FAIL es_block_done got %b want 1", done); end
        if (step_out !== '0) begin n_fail++; $display("FAIL es_block_step got %b want 0", step_out); end
        if (endstop_hit !== 1'b1) begin n_fail++; $display("FAIL es_block_hit got %b want 1", endstop_hit); end
        if (steps_remaining !== {32'sd0, 32'sd7, 32'sd7}) begin
            n_fail++; $display("FAIL es_block_rem got %h want 0/7/7", steps_remaining);
        end
        endstop_max = '0;
        @(negedge clk);
        // Y has zero motion, so its min endstop must not block.
        endstop_min = 3'b010;
        pulse_start();
        prev = step_out;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (step_out[0] && !prev[0]) rises0++;
            if (step_out[1] && !prev[1]) rises1++;
            prev = step_out;
            if (done) done_k = k;
        end
        endstop_min = '0;
        n_vec += 4;
        if (rises0 != 10 || rises1 != 10) begin
            n_fail++; $display("FAIL es_ignore_pulses got %0d/%0d want 10/10", rises0, rises1);
        end
        if (done_k != 21) begin n_fail++; $display("FAIL es_ignore_done got %0d want 21", done_k); end
        if (endstop_hit !== 1'b0) begin n_fail++; $display("FAIL es_ignore_hit got %b want 0", endstop_hit); end
        if (steps_remaining !== '0) begin
            n_fail++; $display("FAIL es_ignore_rem got %h want 0", steps_remaining);
        end
    endtask

    task automatic test_abort();
        m_steps  = '{8, 0, 0};
        m_hp_raw = '{2, 1, 1};
        apply_move();
        pulse_start();
        repeat (14) @(negedge clk);
        n_vec++;
        if (step_out[0] !== 1'b1) begin n_fail++; $display("FAIL abort_pre_high got %b want 1", step_out[0]); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec += 4;
        if (step_out !== '0) begin n_fail++; $display("FAIL abort_step got %b want 0", step_out); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL abort_done got %b want 1", done); end
        if (endstop_hit !== 1'b0) begin n_fail++; $display("FAIL abort_hit got %b want 0", endstop_hit); end
        if (steps_remaining[SW-1:0] !== 32'd4) begin
            n_fail++; $display("FAIL abort_rem got %0d want 4", steps_remaining[SW-1:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_most_negative();
        m_steps  = '{-64'sd2147483648, 0, 0};
        m_hp_raw = '{0, 0, 0};
        apply_move();
        pulse_start();
        n_vec++;
        if (dir_out[0] !== 1'b1) begin n_fail++; $display("FAIL neg_dir got %b want 1", dir_out[0]); end
        repeat (1000) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec += 2;
        if (done !== 1'b1) begin n_fail++; $display("FAIL neg_done got %b want 1", done); end
        if (steps_remaining[SW-1:0] !== 32'h8000_01f4) begin
            n_fail++; $display("FAIL neg_rem got %h want 800001f4", steps_remaining[SW-1:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            longint kf, done_k, kill_at, abort_at, es_at, k_sp, iss;
            int mode, es_axis;
            bit es_is_max, blocking, killed, exp_hit;
            logic [NCH*SW-1:0] exp_rem, fin_rem;
            logic [NCH-1:0] exp_step, exp_dir;
            for (int c = 0; c < NCH; c++) begin
                m_steps[c] = longint'($urandom_range(10)) - 5;
                if ($urandom_range(3) == 0) m_steps[c] = 0;
                m_hp_raw[c] = longint'($urandom_range(3));
            end
            apply_move();
            kf = m_last_edge();
            mode = (kf == 0) ? 0 : int'($urandom_range(3));
            abort_at = 1 + longint'($urandom_range(int'(kf)));
            es_at    = 1 + longint'($urandom_range(int'(kf) + 1));
            es_axis  = int'($urandom_range(NCH - 1));
            es_is_max = 1'($urandom_range(1));
            blocking = (mode >= 2) && (es_at <= kf + 1) &&
                       ((es_is_max && m_axis_dir(es_axis) == 1) ||
                        (!es_is_max && m_axis_dir(es_axis) == -1));
            kill_at = 64'd1 << 40;
            if (mode == 1 || mode == 3) kill_at = abort_at;
            if (blocking && es_at < kill_at) kill_at = es_at;
            exp_hit = blocking && (es_at <= kill_at);
            killed  = (kf != 0) && (kill_at <= kf + 1);
            done_k  = (kf == 0) ? 0 : (killed ? kill_at : kf + 1);
            k_sp    = 1 + longint'($urandom_range(int'(done_k)));
            for (int c = 0; c < NCH; c++) begin
                iss = killed ? m_issued(c, kill_at - 1) + m_high(c, kill_at - 1) : m_mag(c);
                fin_rem[c*SW +: SW] = m_rem(c, iss)[SW-1:0];
                exp_dir[c] = (m_steps[c] < 0);
            end
            pulse_start();
            for (longint k = 0; k <= done_k + 1; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    exp_step[c] = (k < done_k) ? m_high(c, k)[0] : 1'b0;
                    exp_rem[c*SW +: SW] = (k < done_k) ? m_rem(c, m_issued(c, k))[SW-1:0]
                                                       : fin_rem[c*SW +: SW];
                end
                n_vec += 6;
                if (step_out !== exp_step) begin
                    n_fail++; $display("FAIL rnd_step it=%0d k=%0d got %b want %b", it, k, step_out, exp_step);
                end
                if (dir_out !== exp_dir) begin
                    n_fail++; $display("FAIL rnd_dir it=%0d k=%0d got %b want %b", it, k, dir_out, exp_dir);
                end
                if (busy !== (k < done_k)) begin
                    n_fail++; $display("FAIL rnd_busy it=%0d k=%0d got %b want %b", it, k, busy, k < done_k);
                end
                if (done !== (k == done_k)) begin
                    n_fail++; $display("FAIL rnd_done it=%0d k=%0d got %b want %b", it, k, done, k == done_k);
                end
                if (endstop_hit !== ((k >= done_k) && exp_hit)) begin
                    n_fail++;
                    $display("FAIL rnd_hit it=%0d k=%0d got %b want %b", it, k, endstop_hit,
                             (k >= done_k) && exp_hit);
                end
                if (steps_remaining !== exp_rem) begin
                    n_fail++;
                    $display("FAIL rnd_rem it=%0d k=%0d got %h want %h", it, k, steps_remaining, exp_rem);
                end
                // Stimulus for the next rising edge (k + 1).
                abort = (mode == 1 || mode == 3) && (k + 1 == abort_at);
                if (mode >= 2 && k + 1 >= es_at) begin
                    if (es_is_max) endstop_max[es_axis] = 1'b1;
                    else endstop_min[es_axis] = 1'b1;
                end
                start = (k + 1 == k_sp);
                if (start) begin
                    steps_in = {$urandom, $urandom, $urandom};
                    half_period_in = {$urandom, $urandom, $urandom};
                end
                @(negedge clk);
            end
            start = 1'b0;
            abort = 1'b0;
            endstop_min = '0;
            endstop_max = '0;
        end
    endtask

    task automatic test_reset_midmove();
        int done_k = -1;
        m_steps  = '{5, -3, 0};
        m_hp_raw = '{2, 4, 1};
        apply_move();
        pulse_start();
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec += 5;
        if (step_out !== '0) begin n_fail++; $display("FAIL rstmid_step got %b want 0", step_out); end
        if (dir_out !== '0) begin n_fail++; $display("FAIL rstmid_dir got %b want 0", dir_out); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
        if (steps_remaining !== '0) begin
            n_fail++; $display("FAIL rstmid_rem got %h want 0", steps_remaining);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done got %b want 0", done); end
        rst = 1'b0;
        pulse_start();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) done_k = k;
        end
        n_vec += 2;
        if (done_k != 25) begin n_fail++; $display("FAIL rstmid_rerun_done got %0d want 25", done_k); end
        if (steps_remaining !== '0) begin
            n_fail++; $display("FAIL rstmid_rerun_rem got %h want 0", steps_remaining);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_endstop();
        test_abort();
        test_most_negative();
        test_random();
        test_reset_midmove();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
